// File: rtl/arith_pkg.sv
// arith_pkg: shared encodings for the arithmetic sequencer.
//   - sel operation codes (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
//   - sequencer state encoding (IDLE, CALC, DONE)
//   - iteration count for the multi-cycle multiply/divide
package arith_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam int unsigned ITERATIONS = 32'd4;
   // Counter value seen during the final iteration.
   localparam logic [1:0]  LAST_ITER  = 2'(ITERATIONS - 32'd1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage : arith_pkg

// File: rtl/arith_iter_step.sv
// arith_iter_step: one combinational iteration of either
//   - shift-add multiply: acc = {partial_hi[3:0], multiplier_remaining[3:0]},
//     multiplier consumed LSB first, product shifts in from the top;
//   - restoring divide:   acc = {remainder[3:0], dividend/quotient[3:0]},
//     dividend consumed MSB first, quotient bits shift in at the bottom.
// Ports:
//   div_mode  in  1  1 = restoring-divide step, 0 = shift-add step
//   acc       in  8  current accumulator
//   operand   in  4  multiplicand (multiply) or divisor (divide)
//   acc_next  out 8  accumulator after this iteration
module arith_iter_step
   import arith_pkg::*;
(
   input  logic       div_mode,
   input  logic [7:0] acc,
   input  logic [3:0] operand,
   output logic [7:0] acc_next
);

   logic [4:0] hi_sum_s;
   logic [4:0] shl_s;
   logic [3:0] diff_s;

   // Single iteration of the selected algorithm.
   always_comb begin
      hi_sum_s = {1'b0, acc[7:4]};
      shl_s    = {acc[7:4], acc[3]};
      // Only the low nibble is kept: when the subtraction is taken the
      // true difference is below the divisor, so it always fits.
      diff_s   = shl_s[3:0] - operand;
      acc_next = acc;
      if (div_mode) begin
         if (shl_s >= {1'b0, operand}) begin
            acc_next = {diff_s, acc[2:0], 1'b1};
         end else begin
            acc_next = {shl_s[3:0], acc[2:0], 1'b0};
         end
      end else begin
         if (acc[0]) begin
            hi_sum_s = {1'b0, acc[7:4]} + {1'b0, operand};
         end else begin
            hi_sum_s = {1'b0, acc[7:4]};
         end
         // Carry out of the add becomes the new top bit as everything shifts right.
         acc_next = {hi_sum_s, acc[3:1]};
      end
   end

endmodule : arith_iter_step

// File: rtl/arith_sequencer.sv
// arith_sequencer: 4-bit add/subtract/multiply/divide sequencer.
// Add and subtract finish in one CALC cycle; multiply and divide run four
// iterations of arith_iter_step and publish on the following edge.
// Ports:
//   clk          in  1  rising-edge clock
//   rst_n        in  1  synchronous active-low reset
//   x, y         in  4  operands (y is the divisor), latched on start acceptance
//   sel          in  2  operation select, latched on start acceptance
//   start        in  1  begin an operation (honoured only in IDLE)
//   out          out 8  registered result, held until the next result edge
//   busy         out 1  high whenever the sequencer is not IDLE
//   done         out 1  high for the single DONE cycle
//   div_by_zero  out 1  flag for the most recent completed operation
module arith_sequencer
   import arith_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [1:0] sel,
   input  logic       start,
   output logic [7:0] out,
   output logic       busy,
   output logic       done,
   output logic       div_by_zero
);

   state_t     state_r, state_s;
   logic [3:0] x_r, x_s;
   logic [3:0] y_r, y_s;
   logic [1:0] op_r, op_s;
   logic [7:0] acc_r, acc_s;
   logic [1:0] cnt_r, cnt_s;
   logic       fin_r, fin_s;
   logic [7:0] out_r, out_s;
   logic       dbz_r, dbz_s;
   logic       busy_r, done_r;
   logic       div_mode_s;
   logic [3:0] step_operand_s;
   logic [7:0] step_acc_s;

   assign div_mode_s     = (op_r == OP_DIV);
   assign step_operand_s = div_mode_s ? y_r : x_r;

   arith_iter_step u_step (
      .div_mode (div_mode_s),
      .acc      (acc_r),
      .operand  (step_operand_s),
      .acc_next (step_acc_s)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_s = state_r;
      x_s     = x_r;
      y_s     = y_r;
      op_s    = op_r;
      acc_s   = acc_r;
      cnt_s   = cnt_r;
      fin_s   = fin_r;
      out_s   = out_r;
      dbz_s   = dbz_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = CALC;
               x_s     = x;
               y_s     = y;
               op_s    = sel;
               cnt_s   = 2'd0;
               fin_s   = 1'b0;
               // Multiply consumes the multiplier from the low nibble;
               // divide consumes the dividend from the low nibble.
               if (sel == OP_MUL) begin
                  acc_s = {4'h0, y};
               end else begin
                  acc_s = {4'h0, x};
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            case (op_r)
               OP_ADD: begin
                  out_s   = {4'h0, x_r} + {4'h0, y_r};
                  dbz_s   = 1'b0;
                  state_s = DONE;
               end
               OP_SUB: begin
                  out_s   = {4'h0, x_r} - {4'h0, y_r};
                  dbz_s   = 1'b0;
                  state_s = DONE;
               end
               OP_MUL, OP_DIV: begin
                  if ((op_r == OP_DIV) && (y_r == 4'h0)) begin
                     out_s   = 8'hFF;
                     dbz_s   = 1'b1;
                     state_s = DONE;
                  end else if (fin_r) begin
                     // Publish one edge after the fourth iteration.
                     out_s   = acc_r;
                     dbz_s   = 1'b0;
                     state_s = DONE;
                  end else begin
                     acc_s = step_acc_s;
                     cnt_s = cnt_r + 2'd1;
                     if (cnt_r == LAST_ITER) begin
                        fin_s = 1'b1;
                     end else begin
                        fin_s = 1'b0;
                     end
                  end
               end
               default: begin
                  state_s = IDLE;
               end
            endcase
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         x_r     <= 4'h0;
         y_r     <= 4'h0;
         op_r    <= OP_ADD;
         acc_r   <= 8'h00;
         cnt_r   <= 2'd0;
         fin_r   <= 1'b0;
         out_r   <= 8'h00;
         dbz_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         x_r     <= x_s;
         y_r     <= y_s;
         op_r    <= op_s;
         acc_r   <= acc_s;
         cnt_r   <= cnt_s;
         fin_r   <= fin_s;
         out_r   <= out_s;
         dbz_r   <= dbz_s;
         // Flag registers track the state being entered so they match it exactly.
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == DONE);
      end
   end

   assign out         = out_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign div_by_zero = dbz_r;

endmodule : arith_sequencer

// File: tb/tb_arith_sequencer.sv
// tb_arith_sequencer: directed self-checking bench for arith_sequencer.
module tb_arith_sequencer;

   logic       clk;
   logic       rst_n;
   logic [3:0] x;
   logic [3:0] y;
   logic [1:0] sel;
   logic       start;
   logic [7:0] out;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   arith_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (x),
      .y           (y),
      .sel         (sel),
      .start       (start),
      .out         (out),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
      sel   = s;
      x     = a;
      y     = b;
      start = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b1;   // must be ignored while in reset
      sel   = 2'b00;
      x     = 4'd9;
      y     = 4'd7;
      tick();
      tick();
      chk8("rst_out", out, 8'h00);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_dbz", div_by_zero, 1'b0);

      // Add 9+7: accepted at the first edge with rst_n high.
      rst_n = 1'b1;
      tick();                          // E0
      start = 1'b0;
      chk1("add_busy_e0", busy, 1'b1);
      chk1("add_done_e0", done, 1'b0);
      chk8("add_out_e0", out, 8'h00);
      tick();                          // E1
      chk8("add_out", out, 8'h10);
      chk1("add_done_e1", done, 1'b1);
      chk1("add_busy_e1", busy, 1'b1);
      tick();                          // E2
      chk1("add_done_e2", done, 1'b0);
      chk1("add_busy_e2", busy, 1'b0);
      chk8("add_out_hold", out, 8'h10);

      // Subtract 3-5 wraps to FE.
      issue(2'b01, 4'd3, 4'd5);
      tick();
      start = 1'b0;
      tick();
      chk8("sub_out", out, 8'hFE);
      chk1("sub_dbz", div_by_zero, 1'b0);
      chk1("sub_done", done, 1'b1);
      tick();

      // Multiply 15*15 with a stray start at E2.
      issue(2'b10, 4'd15, 4'd15);
      tick();                          // E0
      start = 1'b0;
      tick();                          // E1
      chk8("mul_out_e1", out, 8'hFE);
      issue(2'b00, 4'd1, 4'd1);
      tick();                          // E2
      start = 1'b0;
      chk8("mul_out_e2", out, 8'hFE);
      chk1("mul_busy_e2", busy, 1'b1);
      tick();                          // E3
      chk8("mul_out_e3", out, 8'hFE);
      tick();                          // E4
      chk8("mul_out_e4", out, 8'hFE);
      chk1("mul_done_e4", done, 1'b0);
      tick();                          // E5
      chk8("mul_out", out, 8'hE1);
      chk1("mul_done_e5", done, 1'b1);
      tick();                          // E6
      chk1("mul_done_e6", done, 1'b0);
      chk1("mul_busy_e6", busy, 1'b0);
      tick();                          // stray start was not queued
      chk1("mul_noqueue_busy", busy, 1'b0);
      chk8("mul_noqueue_out", out, 8'hE1);

      // Divide 13/4 -> rem 1, quot 3.
      issue(2'b11, 4'd13, 4'd4);
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();                          // E4
      chk1("div_done_e4", done, 1'b0);
      chk8("div_out_e4", out, 8'hE1);
      tick();                          // E5
      chk8("div_out", out, 8'h13);
      chk1("div_done_e5", done, 1'b1);
      chk1("div_dbz", div_by_zero, 1'b0);
      tick();

      // Divide by zero.
      issue(2'b11, 4'd7, 4'd0);
      tick();
      start = 1'b0;
      chk1("dbz_done_e0", done, 1'b0);
      tick();
      chk8("dbz_out", out, 8'hFF);
      chk1("dbz_flag", div_by_zero, 1'b1);
      chk1("dbz_done_e1", done, 1'b1);
      tick();
      chk1("dbz_busy_e2", busy, 1'b0);
      chk1("dbz_flag_hold", div_by_zero, 1'b1);

      // Reset mid-multiply.
      issue(2'b10, 4'd6, 4'd5);
      tick();                          // E0
      start = 1'b0;
      tick();                          // E1
      rst_n = 1'b0;
      tick();                          // E2
      chk8("midrst_out", out, 8'h00);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_done", done, 1'b0);
      chk1("midrst_dbz", div_by_zero, 1'b0);
      rst_n = 1'b1;
      tick();
      chk1("midrst_idle", busy, 1'b0);

      // Fresh 6*5.
      issue(2'b10, 4'd6, 4'd5);
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      tick();                          // E5
      chk8("mul65_out", out, 8'h1E);
      chk1("mul65_done", done, 1'b1);
      tick();

      // Back-to-back adds with start held high: accepted every 3 cycles.
      issue(2'b00, 4'd1, 4'd1);
      tick();                          // E0
      chk1("b2b_busy_e0", busy, 1'b1);
      tick();                          // E1
      chk8("b2b_out1", out, 8'h02);
      chk1("b2b_done1", done, 1'b1);
      chk1("b2b_dbz1", div_by_zero, 1'b0);
      tick();                          // E2
      chk1("b2b_busy_e2", busy, 1'b0);
      chk1("b2b_done_e2", done, 1'b0);
      tick();                          // E3
      chk1("b2b_busy_e3", busy, 1'b1);
      chk1("b2b_done_e3", done, 1'b0);
      tick();                          // E4
      chk8("b2b_out2", out, 8'h02);
      chk1("b2b_done2", done, 1'b1);
      tick();                          // E5
      chk1("b2b_busy_e5", busy, 1'b0);
      tick();                          // E6
      chk1("b2b_busy_e6", busy, 1'b1);
      start = 1'b0;
      tick();
      tick();
      chk1("b2b_final_idle", busy, 1'b0);
      chk1("b2b_final_done", done, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_arith_sequencer

// File: doc/arith_sequencer.md
ARITH_SEQUENCER -- requirements
Module: arith_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port rst_n, input, 1, synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port x, input, 4, unsigned operand A; sampled only on start acceptance.
REQ-005 Port y, input, 4, unsigned operand B (divisor for divide); sampled only on start acceptance.
REQ-006 Port sel, input, 2, operation: 00 add, 01 subtract, 10 multiply, 11 divide; sampled only on start acceptance.
REQ-007 Port start, input, 1, request to begin an operation.
REQ-008 Port out, output, 8, registered result.
REQ-009 Port busy, output, 1, high while an operation is in progress.
REQ-010 Port done, output, 1, one-cycle pulse marking out valid for the new result.
REQ-011 Port div_by_zero, output, 1, registered flag for the most recent completed operation.

Function
REQ-012 States SHALL be IDLE, CALC, DONE; busy = (state != IDLE).
REQ-013 Start SHALL be accepted only when state is IDLE and start=1 at edge E0; x, y and sel are latched at E0.
REQ-014 start SHALL be ignored in CALC and DONE, with no queuing.
REQ-015 Add: at E1, out = {4'b0,x}+{4'b0,y}; state goes to DONE.
REQ-016 Subtract: at E1, out = ({4'b0,x}-{4'b0,y}) mod 256, e.g. 3-5 = 8'hFE; state goes to DONE.
REQ-017 Multiply: shift-add over exactly 4 CALC iterations (E1..E4), one multiplier bit per cycle, LSB first; at E5, out = x*y (8-bit exact) and state goes to DONE.
REQ-018 Divide with y!=0: restoring division over exactly 4 CALC iterations (E1..E4), one quotient bit per cycle, MSB first; at E5, out = {remainder[3:0], quotient[3:0]} and state goes to DONE.
REQ-019 Divide with y=0: CALC SHALL be skipped; at E1, out=8'hFF, div_by_zero=1, state goes to DONE.
REQ-020 div_by_zero SHALL update only when out updates, and is 0 for every other completion.
REQ-021 done SHALL be 1 exactly in the DONE state: one cycle after the result edge; DONE always returns to IDLE on the next edge.
REQ-022 out SHALL hold its last completed value through IDLE and during the next operation until that operation's result edge; intermediate partials never appear on out.
REQ-023 An iteration counter (2 bits) SHALL terminate CALC after exactly 4 cycles independent of operand values, including zero operands.
REQ-024 Latency, start edge to done high: add/sub/divide-by-zero 2 cycles, multiply/divide 6 cycles; a back-to-back start is acceptable at the first IDLE cycle after DONE.

Reset
REQ-025 When rst_n=0 at a clk edge, state SHALL go to IDLE and out=8'h00, busy=0, done=0, div_by_zero=0, counter=0, in any state including mid-CALC.
REQ-026 start SHALL be ignored in any cycle where rst_n=0; the first acceptance is possible at the first edge with rst_n=1.

Structure
REQ-027 A shared package arith_pkg SHALL hold the sel encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the state encoding, and ITERATIONS=4.
REQ-028 One combinational sub-module arith_iter_step SHALL compute a single shift-add or restoring-subtract iteration; the sequencer instantiates it once.
REQ-029 The RTL SHALL contain no combinational '*' or '/' operators.

Verification
REQ-030 Reset, then start with sel=00, x=9, y=7 -> out=8'h10, done high only in the cycle after E1, busy 2 cycles.
REQ-031 sel=01, x=3, y=5 -> out=8'hFE at E1, div_by_zero=0.
REQ-032 sel=10, x=15, y=15 -> out=8'hE1 at E5, done at cycle 6; out unchanged E1..E4; start pulsed at E2 is ignored.
REQ-033 sel=11, x=13, y=4 -> out=8'h13 (rem 1, quot 3) at E5; then sel=11, x=7, y=0 -> out=8'hFF, div_by_zero=1, done 2 cycles after start.
REQ-034 Start multiply 6*5, assert rst_n=0 at E2 -> next cycle all outputs 0 and state IDLE; then a fresh 6*5 -> 8'h1E.
REQ-035 Back-to-back: start held high continuously with sel=00, x=1, y=1 -> accepted every 3 cycles, each producing out=8'h02 with a single done pulse.
